// File: rtl/ascii_pkg.sv
// ascii_pkg: definitions shared between the register dump sequencer and the core.
//   dump_state_t : sequencer FSM states
//   TXT_ATTR     : attribute bits appended below every character written to the text buffer
//   hex_to_ascii : 4-bit value -> ASCII '0'-'9' / 'A'-'F'
package ascii_pkg;

    localparam logic [23:0] TXT_ATTR     = 24'hFFFFFF;
    localparam logic [7:0]  ASCII_ZERO   = 8'h30;
    // 'A' - 10, so that nibble 10 lands on 'A'
    localparam logic [7:0]  ASCII_HEX_AF = 8'h37;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCapture,
        StEmit,
        StFinish
    } dump_state_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return ASCII_ZERO + {4'h0, nibble};
        end
        return ASCII_HEX_AF + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// hex_nibble_ascii: combinational 4-bit -> 8-bit ASCII hex digit encoder.
//   nibble : value 0-15
//   ascii  : '0'-'9' (0x30-0x39) or 'A'-'F' (0x41-0x46)
module hex_nibble_ascii
    import ascii_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = hex_to_ascii(nibble);

endmodule

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: walks all architectural registers through the register file debug
// port and prints each as 8 hex characters on its own text row, while sharing the single
// text-buffer write port with CPU stores.
//   clk, rst                 : system clock, asynchronous active-high reset
//   start                    : begin a dump (only honoured while idle)
//   busy, done               : dump in progress / one-cycle completion pulse
//   dbg_reg_addr/dbg_reg_data: register file debug read port
//   cpu_req/addr/data, cpu_gnt: CPU text write request and same-cycle grant
//   txt_we/addr/data         : registered write port to the text buffer
module reg_dump_sequencer
    import ascii_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned COLS      = 80,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned STALL_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           dbg_reg_addr,
    input  logic [WORD_SIZE-1:0] dbg_reg_data,
    input  logic                 cpu_req,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_data,
    output logic                 cpu_gnt,
    output logic                 txt_we,
    output logic [ADDR_W-1:0]    txt_addr,
    output logic [WORD_SIZE-1:0] txt_data
);

    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(WORD_SIZE);

    dump_state_t            state;
    logic [4:0]             reg_idx;
    logic [2:0]             col;
    logic [WORD_SIZE-1:0]   shadow;
    logic [STALL_W-1:0]     stall_cnt;

    logic                   in_emit;
    logic                   forced_slot;
    logic                   dump_issue;
    logic [IDX_W-1:0]       nib_lsb;
    logic [3:0]             nibble;
    logic [7:0]             ascii;
    logic [ADDR_W-1:0]      dump_addr;

    // CPU owns the port unless the dump has been starved STALL_MAX times in a row.
    assign in_emit     = (state == StEmit);
    assign forced_slot = in_emit && (stall_cnt == STALL_W'(STALL_MAX));
    assign cpu_gnt     = cpu_req & ~forced_slot;
    assign dump_issue  = in_emit & ~cpu_gnt;

    // Most significant nibble first.
    assign nib_lsb   = IDX_W'(WORD_SIZE - 4) - IDX_W'({col, 2'b00});
    assign nibble    = shadow[nib_lsb +: 4];
    assign dump_addr = ADDR_W'(reg_idx) * ADDR_W'(COLS) + ADDR_W'(col);

    hex_nibble_ascii u_hex_nibble_ascii (
        .nibble (nibble),
        .ascii  (ascii)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            reg_idx      <= '0;
            col          <= '0;
            shadow       <= '0;
            stall_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dbg_reg_addr <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state        <= StAddr;
                        reg_idx      <= '0;
                        dbg_reg_addr <= '0;
                        busy         <= 1'b1;
                    end
                end
                // dbg_reg_addr was loaded on entry, giving the register file a full cycle.
                StAddr: begin
                    state <= StCapture;
                end
                StCapture: begin
                    shadow <= dbg_reg_data;
                    col    <= '0;
                    state  <= StEmit;
                end
                StEmit: begin
                    if (dump_issue) begin
                        stall_cnt <= '0;
                        if (col == 3'd7) begin
                            if (reg_idx == 5'(NUM_REGS - 1)) begin
                                state <= StFinish;
                                done  <= 1'b1;
                            end else begin
                                reg_idx      <= reg_idx + 5'd1;
                                dbg_reg_addr <= reg_idx + 5'd1;
                                state        <= StAddr;
                            end
                        end else begin
                            col <= col + 3'd1;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                StFinish: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Text-buffer write port; address/data hold their last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txt_we   <= 1'b0;
            txt_addr <= '0;
            txt_data <= '0;
        end else begin
            txt_we <= cpu_gnt | dump_issue;
            if (cpu_gnt) begin
                txt_addr <= cpu_addr;
                txt_data <= cpu_data;
            end else if (dump_issue) begin
                txt_addr <= dump_addr;
                txt_data <= WORD_SIZE'({ascii, TXT_ATTR});
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
`timescale 1ns/1ps
module tb_reg_dump_sequencer;

    localparam int NR   = 32;
    localparam int COLS = 80;
    localparam int AW   = 13;
    localparam int SM   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [4:0]    dbg_reg_addr;
    logic [31:0]   dbg_reg_data;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_data;
    logic          cpu_gnt;
    logic          txt_we;
    logic [AW-1:0] txt_addr;
    logic [31:0]   txt_data;

    logic [31:0]   regs [NR];
    logic          noisy;
    logic [31:0]   noise;

    int cmp_cnt;
    int fail_cnt;

    always #5 clk = ~clk;

    // Register file model; outside the capture cycle it can be made to return junk.
    assign dbg_reg_data = noisy ? noise : regs[dbg_reg_addr];

    reg_dump_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_gnt      (cpu_gnt),
        .txt_we       (txt_we),
        .txt_addr     (txt_addr),
        .txt_data     (txt_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        cmp_cnt++;
        if (act !== want) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Character k (0 = leftmost) of the hex rendering of v, with attribute bits.
    function automatic logic [31:0] exp_char(input logic [31:0] v, input int k);
        int n;
        logic [7:0] a;
        n = int'((v >> (28 - 4 * k)) & 32'hF);
        a = (n < 10) ? 8'(48 + n) : 8'(55 + n);
        return {a, 24'hFFFFFF};
    endfunction

    // mode 0: uncontended (second start at cycle 100, junk debug data outside capture)
    // mode 1: cpu_req held high throughout
    // mode 2: random CPU traffic
    task automatic run_dump(input int mode);
        logic [AW-1:0] ea_q[$];
        logic [31:0]   ed_q[$];
        int seen, done_cnt, done_cyc, busy_cnt, last_vis, lim, stop_cyc, r, k, gnt0;
        logic          p_gnt, p_req;
        logic [AW-1:0] p_addr;
        logic [31:0]   p_data;
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < 8; j++) begin
                ea_q.push_back(AW'(i * COLS + j));
                ed_q.push_back(exp_char(regs[i], j));
            end
        end
        seen = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; last_vis = 0; gnt0 = 0;
        stop_cyc = 3000;
        @(negedge clk);
        start = 1'b1; cpu_req = 1'b0; noisy = 1'b0;
        p_gnt = 1'b0; p_req = 1'b0; p_addr = '0; p_data = '0;
        for (int c = 1; c <= stop_cyc; c++) begin
            @(negedge clk);
            start = (mode == 0 && c == 100);
            noisy = (mode == 0) && ((c - 1) % 10 != 1);
            noise = $urandom;
            if (mode == 1) begin
                cpu_req  = 1'b1;
                cpu_addr = AW'(c);
                cpu_data = 32'h4800_0000 | 32'(c);
            end else if (mode == 2 && (!cpu_req || p_gnt)) begin
                cpu_req  = ($urandom_range(0, 2) != 0);
                cpu_addr = AW'($urandom);
                cpu_data = {8'h52, 12'h0, 12'(c)};
            end
            #1;
            if (p_gnt) begin
                check("cpu write we", 32'(txt_we), 1);
                check("cpu write addr", 32'(txt_addr), 32'(p_addr));
                check("cpu write data", txt_data, p_data);
            end else if (txt_we) begin
                if (ea_q.size() == 0) begin
                    check("extra dump write", 32'(txt_we), 0);
                end else begin
                    r = seen / 8;
                    k = seen % 8;
                    check("dump addr", 32'(txt_addr), 32'(ea_q.pop_front()));
                    check("dump data", txt_data, ed_q.pop_front());
                    if (mode == 0) begin
                        check("dump cycle", c, 10 * r + k + 4);
                    end else if (mode == 1) begin
                        check("dump cycle", c, 42 * r + 5 * k + 8);
                    end else begin
                        lim = (seen == 0) ? SM + 4 : ((k == 0) ? SM + 3 : SM + 1);
                        check("dump starvation gap", 32'((c - last_vis) <= lim), 1);
                    end
                    last_vis = c;
                    seen++;
                end
            end
            if (p_req && !p_gnt) check("refused cpu cycle issues dump", 32'(txt_we), 1);
            if (cpu_gnt && !cpu_req) check("gnt without req", 32'(cpu_gnt), 0);
            if (mode == 1 && !cpu_gnt) gnt0++;
            if (mode == 0 && c <= 320 && (c - 1) % 10 == 0)
                check("dbg_reg_addr in addr cycle", 32'(dbg_reg_addr), (c - 1) / 10);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = c;
                    check("all chars written at done", seen, 256);
                    stop_cyc = c + 3;
                end
            end
            p_gnt = cpu_gnt; p_req = cpu_req; p_addr = cpu_addr; p_data = cpu_data;
        end
        cpu_req = 1'b0; start = 1'b0; noisy = 1'b0;
        check("done pulse count", done_cnt, 1);
        check("dump chars total", seen, 256);
        check("busy cleared after done", 32'(busy), 0);
        if (mode == 0) begin
            check("done cycle", done_cyc, 321);
            check("busy cycles", busy_cnt, 321);
        end else if (mode == 1) begin
            check("done cycle held req", done_cyc, 1345);
            check("busy cycles held req", busy_cnt, 1345);
            check("forced slot count", gnt0, 256);
        end else begin
            check("done with last char", done_cyc, last_vis);
            check("busy cycles random", busy_cnt, done_cyc);
        end
    endtask

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          exp_gnt;
        logic          exp_we;
    } vec_t;

    vec_t vecs [5];

    initial begin
        cmp_cnt = 0; fail_cnt = 0;
        rst = 1'b1; start = 1'b0; cpu_req = 1'b1; cpu_addr = '0; cpu_data = '0;
        noisy = 1'b0; noise = '0;
        for (int i = 0; i < NR; i++) regs[i] = 32'(i) * 32'h1111_1111;

        #1;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset dbg_reg_addr", 32'(dbg_reg_addr), 0);
        check("reset txt_we", 32'(txt_we), 0);
        check("reset txt_addr", 32'(txt_addr), 0);
        check("reset txt_data", txt_data, 0);
        check("reset gnt follows req", 32'(cpu_gnt), 1);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // CPU writes while idle.
        vecs[0] = '{1'b1, 13'h0123, 32'h48FF_FFFF, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 13'h0456, 32'h1234_5678, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 13'h1FFF, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 13'h09B7, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 13'h0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpu_req  = vecs[i].req;
            cpu_addr = vecs[i].addr;
            cpu_data = vecs[i].data;
            #1;
            check("idle cpu_gnt", 32'(cpu_gnt), 32'(vecs[i].exp_gnt));
            @(posedge clk);
            #1;
            check("idle txt_we", 32'(txt_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check("idle txt_addr", 32'(txt_addr), 32'(vecs[i].addr));
                check("idle txt_data", txt_data, vecs[i].data);
            end
        end
        cpu_req = 1'b0;

        run_dump(0);
        run_dump(1);

        // Reset in the middle of a dump, while a character write is visible.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        #1;
        check("pre-reset txt_we", 32'(txt_we), 1);
        check("pre-reset txt_addr", 32'(txt_addr), 4 * COLS + 6);
        rst = 1'b1;
        #1;
        check("async reset txt_we", 32'(txt_we), 0);
        check("async reset busy", 32'(busy), 0);
        check("async reset dbg_reg_addr", 32'(dbg_reg_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        run_dump(0);

        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < NR; i++) regs[i] = $urandom;
            run_dump(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
